// File: rtl/spi_slave_controller_pkg.sv
// Shared definitions for the SPI target: register map, status/control bit
// positions, FSM encoding and the latched bus request.
package spi_slave_controller_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] REG_DATA   = 12'h000;
  localparam logic [ADDR_W-1:0] REG_STATUS = 12'h001;
  localparam logic [ADDR_W-1:0] REG_CTRL   = 12'h002;

  localparam int unsigned STAT_RX_VALID = 0;
  localparam int unsigned STAT_TX_FULL  = 1;
  localparam int unsigned STAT_OVERRUN  = 2;
  localparam int unsigned CTRL_IRQ_EN   = 0;

  // Byte shifted out when firmware has not queued one.
  localparam logic [DATA_W-1:0] TX_IDLE_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin with one-cycle
// rise/fall pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise_c = r_sync & ~r_prev;
  assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_controller.sv
// SPI mode-0 target with a DATA/STATUS/CTRL register window on the core bus.
// Frames are 8 bits MSB first; bytes repeat back-to-back while CS is low.
module spi_slave_controller
  import spi_slave_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              chipSel,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ready,
  output logic              interrupt,
  input  logic              spi_sclk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso
);

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic r_mosi_meta, r_mosi_sync;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk      (clk),
    .rst      (rst),
    .i_din    (spi_sclk),
    .o_rise_c (w_sck_rise),
    .o_fall_c (w_sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .rst      (rst),
    .i_din    (spi_cs),
    .o_rise_c (w_cs_rise),
    .o_fall_c (w_cs_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mosi_meta <= 1'b1;
      r_mosi_sync <= 1'b1;
    end else begin
      r_mosi_meta <= spi_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // Frame FSM
  spi_state_t r_state, w_state_nxt;
  logic w_start, w_abort, w_sample, w_shift;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_sample = w_sck_rise;
          w_shift  = w_sck_fall;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus handshake: accept, then complete with a one-cycle ready.
  bus_req_t r_req;
  logic     r_ready;
  logic     w_accept;

  assign w_accept = chipSel & (mem_rd | mem_wr) & ~r_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_req   <= '0;
    end else begin
      r_ready <= w_accept;
      if (w_accept) r_req <= '{rd: mem_rd, wr: mem_wr, addr: mem_addr, wdata: mem_wdata};
    end
  end

  logic w_rd_data, w_wr_data, w_wr_status, w_wr_ctrl;
  assign w_rd_data   = r_ready & r_req.rd & (r_req.addr == REG_DATA);
  assign w_wr_data   = r_ready & r_req.wr & (r_req.addr == REG_DATA);
  assign w_wr_status = r_ready & r_req.wr & (r_req.addr == REG_STATUS);
  assign w_wr_ctrl   = r_ready & r_req.wr & (r_req.addr == REG_CTRL);

  logic [DATA_W-1:0] r_tx_shift, r_tx_byte, r_rx_data;
  logic [DATA_W-2:0] r_rx_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_rx_valid, r_tx_full, r_overrun, r_irq_en;

  logic [DATA_W-1:0] w_rx_byte, w_tx_next;
  logic              w_byte_done;

  assign w_rx_byte   = {r_rx_shift, r_mosi_sync};
  assign w_tx_next   = r_tx_full ? r_tx_byte : TX_IDLE_BYTE;
  assign w_byte_done = w_sample & (r_bit_cnt == CNT_W'(DATA_W - 1));

  // Shift datapath and register side effects; later assignments win ties.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_tx_byte  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_full  <= 1'b0;
      r_overrun  <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      if (w_start) begin
        r_tx_shift <= w_tx_next;
        r_tx_full  <= 1'b0;
        r_bit_cnt  <= '0;
      end else if (w_abort) begin
        r_rx_shift <= '0;
        r_bit_cnt  <= '0;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_byte[DATA_W-2:0];
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
      end else if (w_shift) begin
        // Counter at zero on a falling edge means a byte just finished.
        if (r_bit_cnt == '0) begin
          r_tx_shift <= w_tx_next;
          r_tx_full  <= 1'b0;
        end else begin
          r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
        end
      end

      if (w_rd_data) r_rx_valid <= 1'b0;
      if (w_wr_status && r_req.wdata[STAT_OVERRUN]) r_overrun <= 1'b0;

      if (w_byte_done) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !w_rd_data) r_overrun <= 1'b1;
      end

      if (w_wr_data) begin
        r_tx_byte <= r_req.wdata;
        r_tx_full <= 1'b1;
      end
      if (w_wr_ctrl) r_irq_en <= r_req.wdata[CTRL_IRQ_EN];
    end
  end

  // Read data reflects register state during the ready cycle itself.
  always_comb begin
    mem_rdata = '0;
    if (r_ready && r_req.rd) begin
      case (r_req.addr)
        REG_DATA:   mem_rdata = r_rx_data;
        REG_STATUS: begin
          mem_rdata[STAT_RX_VALID] = r_rx_valid;
          mem_rdata[STAT_TX_FULL]  = r_tx_full;
          mem_rdata[STAT_OVERRUN]  = r_overrun;
        end
        REG_CTRL:   mem_rdata[CTRL_IRQ_EN] = r_irq_en;
        default:    mem_rdata = '0;
      endcase
    end
  end

  assign ready     = r_ready;
  assign interrupt = r_irq_en & (r_rx_valid | r_overrun);
  assign spi_miso  = (r_state == ST_SHIFT) ? r_tx_shift[DATA_W-1] : 1'b1;

endmodule

// File: tb/tb_spi_slave_controller.sv
// Directed bench for spi_slave_controller: register-access vector table plus
// hand-timed SPI frame sequences acting as the external master.
module tb_spi_slave_controller;

  logic        clk, rst, chipSel, mem_rd, mem_wr;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        ready, interrupt;
  logic        spi_sclk, spi_cs, spi_mosi, spi_miso;

  int n_cmp = 0;
  int n_err = 0;

  spi_slave_controller dut (
    .clk       (clk),
    .rst       (rst),
    .chipSel   (chipSel),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ready     (ready),
    .interrupt (interrupt),
    .spi_sclk  (spi_sclk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [7:0] d);
    chipSel = 1'b1; mem_rd = 1'b1; mem_addr = a;
    @(negedge clk);
    chk("ready_rd", ready, 1);
    d = mem_rdata;
    chipSel = 1'b0; mem_rd = 1'b0;
    @(negedge clk);
    chk("ready_rd_drop", ready, 0);
    chk("rdata_idle", mem_rdata, 0);
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [7:0] d);
    chipSel = 1'b1; mem_wr = 1'b1; mem_addr = a; mem_wdata = d;
    @(negedge clk);
    chk("ready_wr", ready, 1);
    chipSel = 1'b0; mem_wr = 1'b0;
    @(negedge clk);
    chk("ready_wr_drop", ready, 0);
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Master side, SCK = clk/4; MISO sampled at the end of each high phase.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] miso_bits);
    miso_bits = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (2) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (2) @(negedge clk);
      miso_bits = {miso_bits[6:0], spi_miso};
      spi_sclk = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
    logic        exp_irq;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] bits, d;

  initial begin
    vecs[0]  = '{1'b0, 12'h001, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 12'h000, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 12'h002, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 12'h002, 8'h01, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 12'h002, 8'h00, 8'h01, 1'b0};
    vecs[5]  = '{1'b0, 12'h003, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 12'h7FF, 8'hFF, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 12'hFFF, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 12'h002, 8'hFE, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 12'h002, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 12'h002, 8'hFF, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 12'h001, 8'h07, 8'h00, 1'b0};

    rst = 1'b0; chipSel = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    spi_sclk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_irq", interrupt, 0);
    chk("rst_miso", spi_miso, 1);
    rst = 1'b1;
    @(negedge clk);

    // Register access table; CTRL ends with irq_en=1.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        bus_wr(vecs[i].addr, vecs[i].wdata);
      end else begin
        bus_rd(vecs[i].addr, d);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      end
      chk($sformatf("vec%0d_irq", i), interrupt, vecs[i].exp_irq);
    end
    rd_chk("status_after_table", 12'h001, 8'h00);

    // Held strobe: ready must pulse, drop, then pulse again.
    chipSel = 1'b1; mem_rd = 1'b1; mem_addr = 12'h002;
    @(negedge clk); chk("hold_ready_1", ready, 1);
    @(negedge clk); chk("hold_ready_0", ready, 0);
    @(negedge clk); chk("hold_ready_2", ready, 1);
    chipSel = 1'b0; mem_rd = 1'b0;
    @(negedge clk); chk("hold_ready_end", ready, 0);

    // Single byte 0x0A with irq enabled.
    chk("miso_idle", spi_miso, 1);
    cs_low();
    spi_xfer(8'h0A, 8, bits);
    chk("b0A_miso", bits, 8'hFF);
    cs_high();
    rd_chk("b0A_status", 12'h001, 8'h01);
    chk("b0A_irq", interrupt, 1);
    rd_chk("b0A_data", 12'h000, 8'h0A);
    rd_chk("b0A_status_clr", 12'h001, 8'h00);
    chk("b0A_irq_clr", interrupt, 0);

    // Queued TX byte, then idle fill on the next byte of the same frame.
    bus_wr(12'h000, 8'hA5);
    rd_chk("txfull_status", 12'h001, 8'h02);
    cs_low();
    chk("a5_first_miso", spi_miso, 1);
    spi_xfer(8'h3C, 8, bits);
    chk("a5_miso", bits, 8'hA5);
    rd_chk("b3C_data", 12'h000, 8'h3C);
    spi_xfer(8'h5A, 8, bits);
    chk("fill_miso", bits, 8'hFF);
    cs_high();
    rd_chk("b5A_status", 12'h001, 8'h01);
    rd_chk("b5A_data", 12'h000, 8'h5A);

    // Overrun on two unread bytes; cleared by W1C.
    cs_low();
    spi_xfer(8'h11, 8, bits);
    spi_xfer(8'h22, 8, bits);
    cs_high();
    rd_chk("ovr_status", 12'h001, 8'h05);
    chk("ovr_irq", interrupt, 1);
    rd_chk("ovr_data", 12'h000, 8'h22);
    rd_chk("ovr_status_after_rd", 12'h001, 8'h04);
    chk("ovr_irq_after_rd", interrupt, 1);
    bus_wr(12'h001, 8'h04);
    rd_chk("ovr_status_w1c", 12'h001, 8'h00);
    chk("ovr_irq_w1c", interrupt, 0);

    // Aborted partial byte, then a full one.
    cs_low();
    spi_xfer(8'hF0, 5, bits);
    cs_high();
    rd_chk("abort_status", 12'h001, 8'h00);
    cs_low();
    spi_xfer(8'h81, 8, bits);
    cs_high();
    rd_chk("b81_status", 12'h001, 8'h01);
    rd_chk("b81_data", 12'h000, 8'h81);
    rd_chk("b81_status_clr", 12'h001, 8'h00);

    // DATA read clear coincides with the 8th SCK rising of 0x55.
    cs_low();
    spi_xfer(8'h55, 7, bits);
    spi_mosi = 1'b1;
    repeat (2) @(negedge clk);
    spi_sclk = 1'b1;
    @(negedge clk);
    chipSel = 1'b1; mem_rd = 1'b1; mem_addr = 12'h000;
    @(negedge clk);
    chk("race_ready", ready, 1);
    chk("race_rdata_old", mem_rdata, 8'h81);
    chipSel = 1'b0; mem_rd = 1'b0;
    @(negedge clk);
    spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    cs_high();
    rd_chk("race_status", 12'h001, 8'h01);
    rd_chk("race_data", 12'h000, 8'h55);

    // Reset mid-frame with an access in flight.
    cs_low();
    spi_xfer(8'h77, 8, bits);
    cs_high();
    bus_wr(12'h000, 8'hC3);
    cs_low();
    spi_xfer(8'hE1, 4, bits);
    chk("pre_rst_miso_bits", bits[3:0], 4'hC);
    chk("pre_rst_miso", spi_miso, 0);
    chk("pre_rst_irq", interrupt, 1);
    rst = 1'b0; chipSel = 1'b1; mem_rd = 1'b1; mem_addr = 12'h001;
    @(negedge clk);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_rdata", mem_rdata, 0);
    chk("mid_rst_irq", interrupt, 0);
    chk("mid_rst_miso", spi_miso, 1);
    rst = 1'b1; chipSel = 1'b0; mem_rd = 1'b0; spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", ready, 0);
    chk("post_rst_miso", spi_miso, 1);
    rd_chk("post_rst_status", 12'h001, 8'h00);
    rd_chk("post_rst_ctrl", 12'h002, 8'h00);
    rd_chk("post_rst_data", 12'h000, 8'h00);
    cs_low();
    spi_xfer(8'h5A, 8, bits);
    chk("post_rst_tx_fill", bits, 8'hFF);
    cs_high();
    rd_chk("post_rst_rx_status", 12'h001, 8'h01);
    chk("post_rst_irq_off", interrupt, 0);
    rd_chk("post_rst_rx_data", 12'h000, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_controller.md
SPI_SLAVE_CONTROLLER -- requirements
Module: spi_slave_controller

Interface
REQ-001 The block SHALL have exactly one clock and reset: clk input 1 (system clock); rst input 1 (synchronous, active-low reset, sampled on rising clk).
REQ-002 chipSel  input  1  bus select from address_decoder.
REQ-003 mem_rd  input  1  bus read strobe; mem_wr  input  1  bus write strobe.
REQ-004 mem_addr  input  12  register offset.
REQ-005 mem_wdata  input  8  write data; mem_rdata  output  8  read data, valid while ready=1.
REQ-006 ready  output  1  one-cycle bus completion pulse.
REQ-007 interrupt  output  1  level interrupt to core (machineExternalInterrupt).
REQ-008 spi_sclk  input  1; spi_cs  input  1, active-low; spi_mosi  input  1; spi_miso  output  1. External master drives SCK/CS/MOSI.

Function
REQ-009 The block SHALL be the SPI target: mode 0, MSB first, 8-bit frames, back-to-back bytes while spi_cs low.
REQ-010 spi_sclk, spi_cs, spi_mosi SHALL pass through 2-flop synchronizers; edges detected from synchronized values; supported SCK <= clk/4.
REQ-011 Registers: 0x000 DATA (read = RX byte, write = TX byte); 0x001 STATUS (b0 rx_valid, b1 tx_full, b2 overrun, others 0; write 1 to b2 clears overrun); 0x002 CTRL (b0 irq_en, b1 rx_irq_only reserved = 0); other offsets read 0x00, writes ignored.
REQ-012 Bus: access accepted when chipSel & (mem_rd | mem_wr) & ~ready; ready=1 exactly one cycle later for one cycle; register side effects occur in the ready cycle; mem_rdata=0x00 when ready=0.
REQ-013 FSM states IDLE, SHIFT. IDLE->SHIFT on synchronized CS falling edge; SHIFT->IDLE on CS rising edge.
REQ-014 On IDLE->SHIFT: tx_shift loaded with TX byte if tx_full else 0xFF; tx_full cleared; bit_cnt=0; spi_miso = tx_shift[7].
REQ-015 In SHIFT, on SCK rising edge: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt+1 (3-bit, wraps 7->0).
REQ-016 On SCK falling edge: tx_shift shifts left, spi_miso = new MSB; after 8th bit, tx_shift reloads per REQ-014 rule for the next byte.
REQ-017 On the 8th rising edge: rx_data <= completed byte, rx_valid=1; if rx_valid already 1, overrun=1 and rx_data overwritten.
REQ-018 DATA read SHALL clear rx_valid; if a byte completes in the same cycle, rx_valid stays 1 with new data, overrun unchanged.
REQ-019 DATA write sets tx_full and TX byte; write while tx_full overwrites, no error flag.
REQ-020 CS rising mid-byte: partial bits discarded, bit_cnt=0, rx_valid/rx_data unchanged.
REQ-021 spi_miso SHALL be 1 while spi_cs high or in IDLE (no tristate).
REQ-022 interrupt = irq_en & (rx_valid | overrun), combinational from registers.

Reset
REQ-023 On rst=0 at rising clk: FSM IDLE, bit_cnt=0, shifts 0, rx_data 0x00, TX byte 0x00, rx_valid/tx_full/overrun/irq_en 0, ready 0, mem_rdata 0x00, interrupt 0, spi_miso 1, synchronizers load idle values (cs=1, sclk=0, mosi=1).
REQ-024 Reset mid-frame SHALL abort frame; next activity requires a fresh CS falling edge.

Structure
REQ-025 Register offsets, STATUS/CTRL bit positions and FSM encodings SHALL live in shared header spi_slave_defs.vh, also used by firmware tests.
REQ-026 One sub-module spi_sync_edge (2-flop sync + rise/fall pulse outputs), instantiated for SCK and CS; MOSI uses sync only.

Verification
REQ-027 Master sends 0x0A (CS low, 8 SCK at clk/4) -> STATUS=0x01, interrupt=1 with irq_en=1, DATA read=0x0A, then STATUS=0x00, interrupt=0.
REQ-028 Write DATA=0xA5 before frame, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx 0x3C; second byte in same CS returns 0xFF.
REQ-029 Two bytes 0x11, 0x22 without read -> STATUS=0x05, DATA=0x22; write STATUS=0x04 -> STATUS=0x00.
REQ-030 CS rises after 5 bits of 0xF0, then full 0x81 -> only 0x81 received, rx_valid once.
REQ-031 DATA read coinciding with 8th SCK rising of 0x55 -> rx_valid=1, DATA=0x55, overrun=0.
REQ-032 rst=0 asserted mid-frame for 1 cycle -> all outputs at REQ-023 values; ready pulses exactly once per access, latency 1 cycle.
